adc_serialiser_scheduler: RTL and testbench



---
 rtl/adc_serialiser_scheduler_if.sv | 28 ++
 rtl/adc_serialiser_scheduler.sv | 99 +++++++++
 tb/tb_adc_serialiser_scheduler.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_serialiser_scheduler_if.sv
// Request/serialiser bundle between the ADC channel decimators, the frame
// scheduler and the shared 16-bit serialiser.
interface adc_serialiser_scheduler_if #(
  parameter int N_CH = 4,
  parameter int CH_W = 3
);
  logic                 en;
  logic [N_CH-1:0]      ch_valid;
  logic [16*N_CH-1:0]   ch_data;
  logic [N_CH-1:0]      ch_ready;
  logic                 ser_trigger;
  logic [15:0]          ser_data;
  logic [CH_W-1:0]      frame_ch;
  logic                 busy;
  logic                 frame_done;

  // Requester side: decimators plus whatever controls the enable.
  modport master (
    output en, ch_valid, ch_data,
    input  ch_ready, ser_trigger, ser_data, frame_ch, busy, frame_done
  );

  // Scheduler side.
  modport slave (
    input  en, ch_valid, ch_data,
    output ch_ready, ser_trigger, ser_data, frame_ch, busy, frame_done
  );
endinterface

// File: rtl/adc_serialiser_scheduler.sv
// Round-robin scheduler sharing one pulse-triggered 16-bit serialiser between
// N_CH channel decimators, spacing triggers 17+GAP cycles apart.
module adc_serialiser_scheduler #(
  parameter int N_CH = 4,
  parameter int CH_W = 3,
  parameter int GAP  = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  adc_serialiser_scheduler_if.slave    bus
);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] SEND     = 1'b1;
  localparam logic [4:0] LAST_CNT = 5'(15 + GAP);

  logic [0:0]       state;
  logic [4:0]       cnt;
  logic [CH_W-1:0]  ptr;
  logic [CH_W-1:0]  grant;
  logic [CH_W-1:0]  ptr_next;
  logic             found;
  logic [15:0]      grant_word;
  logic [N_CH-1:0]  grant_onehot;

  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch.
    grant        = ptr;
    found        = 1'b0;
    grant_word   = '0;
    grant_onehot = '0;
    // Requesters at or after the pointer win first; otherwise wrap from 0.
    for (int c = 0; c < N_CH; c++) begin
      if (!found && c >= int'(ptr) && bus.ch_valid[c]) begin
        found = 1'b1;
        grant = CH_W'(c);
      end
    end
    for (int c = 0; c < N_CH; c++) begin
      if (!found && bus.ch_valid[c]) begin
        found = 1'b1;
        grant = CH_W'(c);
      end
    end
    for (int c = 0; c < N_CH; c++) begin
      if (grant == CH_W'(c)) begin
        grant_word      = bus.ch_data[16*c +: 16];
        grant_onehot[c] = 1'b1;
      end
    end
    ptr_next = (grant == CH_W'(N_CH - 1)) ? '0 : grant + CH_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      ptr             <= '0;
      bus.ch_ready    <= '0;
      bus.ser_trigger <= 1'b0;
      bus.ser_data    <= '0;
      bus.frame_ch    <= '0;
      bus.busy        <= 1'b0;
      bus.frame_done  <= 1'b0;
    end else begin
      bus.ch_ready    <= '0;
      bus.ser_trigger <= 1'b0;
      bus.frame_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.en && found) begin
            bus.ser_data    <= grant_word;
            bus.ser_trigger <= 1'b1;
            bus.ch_ready    <= grant_onehot;
            bus.frame_ch    <= grant;
            bus.busy        <= 1'b1;
            ptr             <= ptr_next;
            cnt             <= '0;
            state           <= SEND;
          end
        end
        SEND: begin
          // Slot covers the 16 shift edges plus GAP idle cycles; en and
          // requests are deliberately ignored until it ends.
          if (cnt == LAST_CNT) begin
            state          <= IDLE;
            bus.busy       <= 1'b0;
            bus.frame_done <= 1'b1;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_serialiser_scheduler.sv
// Randomised and directed bench for adc_serialiser_scheduler: a time-based slot
// model plus a serialiser model check two instances (GAP=2 and GAP=0).
module tb_adc_serialiser_scheduler;

  localparam int N_CH  = 4;
  localparam int CH_W  = 3;
  localparam int GAP_A = 2;
  localparam int GAP_B = 0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adc_serialiser_scheduler_if #(.N_CH(N_CH), .CH_W(CH_W)) a_if ();
  adc_serialiser_scheduler_if #(.N_CH(N_CH), .CH_W(CH_W)) b_if ();

  adc_serialiser_scheduler #(.N_CH(N_CH), .CH_W(CH_W), .GAP(GAP_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(a_if.slave)
  );
  adc_serialiser_scheduler #(.N_CH(N_CH), .CH_W(CH_W), .GAP(GAP_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(b_if.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Slot model: a grant is possible at edge n once n - last_grant >= 17+gap;
  // every output follows from the age of the last grant.
  int              m_n   [2];
  int              m_g   [2];
  int              m_ptr [2];
  logic [CH_W-1:0] m_ch  [2];
  logic [15:0]     m_dat [2];
  logic            m_trig[2];
  logic            m_busy[2];
  logic            m_done[2];
  logic [N_CH-1:0] m_rdy [2];

  task automatic model_reset(input int i);
    m_n[i] = 0; m_g[i] = -1000; m_ptr[i] = 0; m_ch[i] = '0; m_dat[i] = '0;
    m_trig[i] = 1'b0; m_busy[i] = 1'b0; m_done[i] = 1'b0; m_rdy[i] = '0;
  endtask

  task automatic model_edge(input int i, input int gap, input logic en,
                            input logic [N_CH-1:0] v, input logic [16*N_CH-1:0] d);
    int age;
    int c;
    m_n[i]++;
    if (m_n[i] - m_g[i] >= 17 + gap && en && v != '0) begin
      for (int k = 0; k < N_CH; k++) begin
        c = (m_ptr[i] + k) % N_CH;
        if (v[c]) begin
          m_g[i]   = m_n[i];
          m_ch[i]  = CH_W'(c);
          m_dat[i] = d[16*c +: 16];
          m_ptr[i] = (c + 1) % N_CH;
          break;
        end
      end
    end
    age       = m_n[i] - m_g[i];
    m_trig[i] = (age == 0);
    m_rdy[i]  = (age == 0) ? (N_CH'(1) << m_ch[i]) : '0;
    m_busy[i] = (age <= 15 + gap);
    m_done[i] = (age == 16 + gap);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_edge(0, GAP_A, a_if.en, a_if.ch_valid, a_if.ch_data);
      model_edge(1, GAP_B, b_if.en, b_if.ch_valid, b_if.ch_data);
    end
  end

  task automatic model_check(input int i, input string p, input logic trig,
                             input logic [N_CH-1:0] rdy, input logic [15:0] dat,
                             input logic [CH_W-1:0] fch, input logic busy, input logic done);
    check({p, ".ser_trigger"}, trig, m_trig[i]);
    check({p, ".ch_ready"},    rdy,  m_rdy[i]);
    check({p, ".ser_data"},    dat,  m_dat[i]);
    check({p, ".frame_ch"},    fch,  m_ch[i]);
    check({p, ".busy"},        busy, m_busy[i]);
    check({p, ".frame_done"},  done, m_done[i]);
  endtask

  // Serialiser model: loads on trigger, shifts MSB first for 16 edges, and
  // refuses a new trigger while still shifting.
  typedef struct {
    int          cnt;
    int          frames;
    logic [15:0] sr;
    logic [15:0] got;
    logic [15:0] exp;
  } ser_t;

  ser_t ser_a = '{0, 0, 16'h0, 16'h0, 16'h0};
  ser_t ser_b = '{0, 0, 16'h0, 16'h0, 16'h0};

  task automatic ser_step(inout ser_t s, input string p, input logic trig,
                          input logic [15:0] dat, input logic [15:0] expd);
    if (!rst_n) begin
      s.cnt = 0;
    end else if (trig) begin
      check({p, ".ser_accept"}, 32'(s.cnt == 0), 32'd1);
      s.sr  = dat;
      s.exp = expd;
      s.got = '0;
      s.cnt = 16;
    end else if (s.cnt > 0) begin
      s.got = {s.got[14:0], s.sr[15]};
      s.sr  = {s.sr[14:0], 1'b0};
      s.cnt--;
      if (s.cnt == 0) begin
        check({p, ".ser_word"}, s.got, s.exp);
        s.frames++;
      end
    end
  endtask

  int now    = 0;
  int b_last = -1;
  int a_grants[$];
  int a_times[$];
  bit drop_on_ready = 1'b0;
  bit random_mode   = 1'b0;

  task automatic cycle();
    @(negedge clk);
    now++;
    model_check(0, "a", a_if.ser_trigger, a_if.ch_ready, a_if.ser_data, a_if.frame_ch,
                a_if.busy, a_if.frame_done);
    model_check(1, "b", b_if.ser_trigger, b_if.ch_ready, b_if.ser_data, b_if.frame_ch,
                b_if.busy, b_if.frame_done);
    ser_step(ser_a, "a", a_if.ser_trigger, a_if.ser_data, m_dat[0]);
    ser_step(ser_b, "b", b_if.ser_trigger, b_if.ser_data, m_dat[1]);
    if (!rst_n) b_last = -1;
    else if (b_if.ser_trigger) begin
      if (b_last >= 0) check("b.spacing", now - b_last, 17 + GAP_B);
      b_last = now;
    end
    if (a_if.ser_trigger) begin
      a_grants.push_back(int'(a_if.frame_ch));
      a_times.push_back(now);
    end
    for (int i = 0; i < N_CH; i++)
      if (drop_on_ready && a_if.ch_ready[i]) a_if.ch_valid[i] = 1'b0;
    if (random_mode) begin
      for (int i = 0; i < N_CH; i++) begin
        if (!a_if.ch_valid[i] && $urandom_range(0, 5) == 0) begin
          a_if.ch_data[16*i +: 16] = 16'($urandom);
          a_if.ch_valid[i]         = 1'b1;
        end
      end
      if (a_if.en ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 9) == 0))
        a_if.en = ~a_if.en;
    end
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    a_if.en       = 1'b0;
    a_if.ch_valid = '0;
    random_mode   = 1'b0;
    drop_on_ready = 1'b0;
    cycle();
    cycle();
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_trig(input string tag, input int budget);
    int k;
    k = 0;
    do begin
      cycle();
      k++;
    end while (!a_if.ser_trigger && k < budget);
    if (!a_if.ser_trigger) check({tag, ".timeout"}, 32'd0, 32'd1);
  endtask

  task automatic count_slot(input string tag);
    int busy_cnt;
    int done_cnt;
    busy_cnt = 1;
    done_cnt = 0;
    repeat (25) begin
      cycle();
      busy_cnt += int'(a_if.busy);
      done_cnt += int'(a_if.frame_done);
    end
    check({tag, ".busy_cycles"}, busy_cnt, 16 + GAP_A);
    check({tag, ".done_pulses"}, done_cnt, 1);
  endtask

  int trig_cnt;
  int done_cnt;

  initial begin
    a_if.en       = 1'b0;
    a_if.ch_valid = '0;
    a_if.ch_data  = '0;
    b_if.en       = 1'b1;
    b_if.ch_valid = '1;
    for (int i = 0; i < N_CH; i++) b_if.ch_data[16*i +: 16] = 16'($urandom);

    // Reset state
    do_reset();
    check("rst.ser_trigger", a_if.ser_trigger, 0);
    check("rst.ch_ready",    a_if.ch_ready,    0);
    check("rst.ser_data",    a_if.ser_data,    0);
    check("rst.frame_ch",    a_if.frame_ch,    0);
    check("rst.busy",        a_if.busy,        0);
    check("rst.frame_done",  a_if.frame_done,  0);

    // Single request on channel 0
    drop_on_ready          = 1'b1;
    a_if.ch_data[15:0]     = 16'hA5C3;
    a_if.ch_valid          = 4'b0001;
    a_if.en                = 1'b1;
    wait_trig("t1", 1);
    check("t1.ser_data", a_if.ser_data, 16'hA5C3);
    check("t1.ch_ready", a_if.ch_ready, 4'b0001);
    check("t1.frame_ch", a_if.frame_ch, 0);
    count_slot("t1");

    // Continuous requests from all channels
    do_reset();
    for (int i = 0; i < N_CH; i++) a_if.ch_data[16*i +: 16] = 16'(16'h1111 * (i + 1));
    a_if.ch_valid = '1;
    a_if.en       = 1'b1;
    a_grants.delete();
    a_times.delete();
    repeat (5 * (17 + GAP_A) + 3) cycle();
    check("t2.grant_count", 32'(a_grants.size() >= 5), 32'd1);
    for (int k = 0; k < 5 && k < a_grants.size(); k++) begin
      check("t2.order", a_grants[k], k % N_CH);
      if (k > 0) check("t2.spacing", a_times[k] - a_times[k-1], 17 + GAP_A);
    end

    // Requests arriving during a frame are served from the pointer onwards
    do_reset();
    drop_on_ready          = 1'b1;
    a_if.ch_data[32 +: 16] = 16'hC0DE;
    a_if.ch_valid          = 4'b0100;
    a_if.en                = 1'b1;
    wait_trig("t3", 2);
    check("t3.first", a_if.frame_ch, 2);
    cycle();
    a_if.ch_data[16 +: 16] = 16'h1EE1;
    a_if.ch_data[48 +: 16] = 16'h3EE3;
    a_if.ch_valid          = a_if.ch_valid | 4'b1010;
    a_grants.delete();
    repeat (45) cycle();
    check("t3.grant_count", a_grants.size(), 2);
    if (a_grants.size() == 2) begin
      check("t3.second", a_grants[0], 3);
      check("t3.third",  a_grants[1], 1);
    end

    // Enable gating
    do_reset();
    a_if.ch_valid = '1;
    a_grants.delete();
    repeat (50) cycle();
    check("t4.no_grant_when_disabled", a_grants.size(), 0);
    a_if.en = 1'b1;
    cycle();
    check("t4.grant_on_enable", a_if.ser_trigger, 1);
    check("t4.grant_ch",        a_if.frame_ch,    0);
    cycle();
    cycle();
    a_if.en = 1'b0;
    a_grants.delete();
    trig_cnt = 0;
    done_cnt = 0;
    repeat (40) begin
      cycle();
      done_cnt += int'(a_if.frame_done);
    end
    check("t4.no_regrant", a_grants.size(), 0);
    check("t4.frame_completes", done_cnt, 1);

    // Reset in the middle of a frame
    do_reset();
    drop_on_ready = 1'b1;
    a_if.ch_valid = 4'b0001;
    a_if.en       = 1'b1;
    wait_trig("t5", 2);
    repeat (7) cycle();
    #2 rst_n = 1'b0;
    #1;
    check("t5.ser_trigger", a_if.ser_trigger, 0);
    check("t5.ch_ready",    a_if.ch_ready,    0);
    check("t5.ser_data",    a_if.ser_data,    0);
    check("t5.frame_ch",    a_if.frame_ch,    0);
    check("t5.busy",        a_if.busy,        0);
    check("t5.frame_done",  a_if.frame_done,  0);
    a_if.ch_data[32 +: 16] = 16'h7E57;
    a_if.ch_valid          = 4'b0100;
    cycle();
    #1 rst_n = 1'b1;
    wait_trig("t5b", 2);
    check("t5.regrant_ch",   a_if.frame_ch, 2);
    check("t5.regrant_data", a_if.ser_data, 16'h7E57);
    count_slot("t5");

    // Randomised traffic with random enable toggling
    do_reset();
    random_mode   = 1'b1;
    drop_on_ready = 1'b1;
    a_if.en       = 1'b1;
    a_grants.delete();
    repeat (1500) cycle();
    check("t6.activity", 32'(a_grants.size() > 10), 32'd1);
    check("b.frames",    32'(ser_b.frames > 50),    32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
